id_ex_stage: RTL and testbench

- ID/EX pipeline register plus EX-side operand preparation. It sits directly upstream of the ALU.
- It captures decoded instruction fields each cycle and decodes the 4-bit ALU operation. It resolves EX/MEM and MEM/WB forwarding and presents operand1/operand2/operation to the ALU.
- It also detects load-use hazards and inserts a bubble.

---
 rtl/id_ex_stage_pkg.sv | 24 ++
 rtl/id_ex_stage_alu_control.sv | 25 ++
 rtl/id_ex_stage.sv | 107 ++++++++++
 tb/tb_id_ex_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared ALU operation codes, alu_op encodings and ctrl bit indices
package id_ex_stage_pkg;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_XOR   = 4'b1010;
  localparam logic [3:0] ALU_UNSUP = 4'b1111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;
  localparam int CTRL_REG_WRITE  = 4;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_BRANCH     = 1;
  localparam int CTRL_MEM_TO_REG = 0;
  function automatic logic is_shift(input logic [3:0] op);
    return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
  endfunction
endpackage

// File: rtl/id_ex_stage_alu_control.sv
// alu_control: decodes alu_op/funct3/funct7b5 into a 4-bit ALU operation
//   alu_op in 2, funct3 in 3, funct7b5 in 1, operation out 4
module alu_control
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] operation
);
  logic [3:0] arith;
  always_comb begin
    arith = ALU_UNSUP;
    case (funct3)
      3'b000: arith = (alu_op == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111: arith = ALU_AND;
      3'b110: arith = ALU_OR;
      3'b100: arith = ALU_XOR;
      3'b001: arith = ALU_SLL;
      3'b101: arith = funct7b5 ? ALU_SRA : ALU_SRL;
      default: arith = ALU_UNSUP;
    endcase
    operation = alu_op == ALUOP_ADD ? ALU_ADD : alu_op == ALUOP_SUB ? ALU_SUB : arith;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with forwarding, operand muxing and load-use bubble insertion
//   inputs : clk, rst_n, stall, flush, id_* decoded fields, exmem_*/memwb_* forwarding sources
//   outputs: load_use_stall, ex_valid, ex_pc, ex_operand1/2, ex_operation, ex_store_data, ex_rd, ex_ctrl
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [1:0]      id_alu_op,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            id_alu_src,
  input  logic [4:0]      id_ctrl,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic            load_use_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_operand1,
  output logic [XLEN-1:0] ex_operand2,
  output logic [3:0]      ex_operation,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd,
  output logic [4:0]      ex_ctrl
);
  logic [3:0]      id_operation;
  logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q;
  logic [RA_W-1:0] rs1_q, rs2_q;
  logic            alu_src_q;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2, op2_raw;
  logic            bubble;
  alu_control u_alu_control (
    .alu_op    (id_alu_op),
    .funct3    (id_funct3),
    .funct7b5  (id_funct7b5),
    .operation (id_operation)
  );
  assign load_use_stall = id_valid & ex_valid & ex_ctrl[CTRL_MEM_READ] & (ex_rd != '0) &
                          (ex_rd == id_rs1 | ex_rd == id_rs2);
  assign bubble = flush | (!stall & load_use_stall);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      ex_rd        <= '0;
      alu_src_q    <= 1'b0;
      ex_ctrl      <= '0;
      ex_operation <= '0;
    end else if (bubble) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      ex_rd        <= '0;
      alu_src_q    <= 1'b0;
      ex_ctrl      <= '0;
      ex_operation <= '0;
    end else if (!stall) begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      rs1_data_q   <= id_rs1_data;
      rs2_data_q   <= id_rs2_data;
      imm_q        <= id_imm;
      rs1_q        <= id_rs1;
      rs2_q        <= id_rs2;
      ex_rd        <= id_rd;
      alu_src_q    <= id_alu_src;
      ex_ctrl      <= id_ctrl;
      ex_operation <= id_operation;
    end
  end
  // EX/MEM is younger than MEM/WB, so it takes precedence; x0 is never forwarded
  assign fwd_rs1 = (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs1_q) ? exmem_result :
                   (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs1_q) ? memwb_result : rs1_data_q;
  assign fwd_rs2 = (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs2_q) ? exmem_result :
                   (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs2_q) ? memwb_result : rs2_data_q;
  assign op2_raw       = alu_src_q ? imm_q : fwd_rs2;
  // the ALU shifts by all of operand2, and the SRAI immediate carries bit 10
  assign ex_operand2   = is_shift(ex_operation) ? {{(XLEN-5){1'b0}}, op2_raw[4:0]} : op2_raw;
  assign ex_operand1   = fwd_rs1;
  assign ex_store_data = fwd_rs2;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  id_alu_op;
  logic [2:0]  id_funct3;
  logic        id_funct7b5, id_alu_src;
  logic [4:0]  id_ctrl;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        load_use_stall, ex_valid;
  logic [31:0] ex_pc, ex_operand1, ex_operand2, ex_store_data;
  logic [3:0]  ex_operation;
  logic [4:0]  ex_rd, ex_ctrl;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .id_alu_src(id_alu_src), .id_ctrl(id_ctrl),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_operand1(ex_operand1), .ex_operand2(ex_operand2), .ex_operation(ex_operation),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input logic [1:0] op, input logic [2:0] f3, input logic f7, input logic src,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    id_alu_op = op; id_funct3 = f3; id_funct7b5 = f7; id_alu_src = src;
    id_rs1_data = a; id_rs2_data = b; id_imm = imm;
  endtask
  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b0; id_pc = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_ctrl = '0;
    instr(2'b00, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    step(); step();
    chk("rst_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_op", {28'b0, ex_operation}, 32'd0);
    chk("rst_op1", ex_operand1, 32'd0);
    chk("rst_op2", ex_operand2, 32'd0);
    chk("rst_lus", {31'b0, load_use_stall}, 32'd0);
    rst_n = 1'b1;
    // R-type SUB
    id_valid = 1'b1; id_pc = 32'h100; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3; id_ctrl = 5'b10000;
    instr(2'b10, 3'b000, 1'b1, 1'b0, 32'd10, 32'd3, 32'h0);
    chk("pre_capture_valid", {31'b0, ex_valid}, 32'd0);
    step();
    chk("sub_op", {28'b0, ex_operation}, 32'h6);
    chk("sub_op1", ex_operand1, 32'd10);
    chk("sub_op2", ex_operand2, 32'd3);
    chk("sub_store", ex_store_data, 32'd3);
    chk("sub_pc", ex_pc, 32'h100);
    chk("sub_rd", {27'b0, ex_rd}, 32'd3);
    chk("sub_ctrl", {27'b0, ex_ctrl}, 32'h10);
    chk("sub_valid", {31'b0, ex_valid}, 32'd1);
    // SRAI: immediate bit 10 must be masked from the shift amount
    instr(2'b11, 3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h55, 32'h404);
    step();
    chk("srai_op", {28'b0, ex_operation}, 32'h9);
    chk("srai_op2", ex_operand2, 32'h4);
    chk("srai_op1", ex_operand1, 32'h8000_0000);
    // ADDI with funct7b5 set still adds; immediate not masked
    instr(2'b11, 3'b000, 1'b1, 1'b1, 32'd7, 32'd9, 32'hFFFF_FFFC);
    step();
    chk("addi_op", {28'b0, ex_operation}, 32'h2);
    chk("addi_op2", ex_operand2, 32'hFFFF_FFFC);
    // R-type SLT unsupported, SRL with register shift amount
    instr(2'b10, 3'b010, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0);
    step();
    chk("slt_op", {28'b0, ex_operation}, 32'hF);
    instr(2'b10, 3'b101, 1'b0, 1'b0, 32'hF0, 32'h123, 32'h0);
    step();
    chk("srl_op", {28'b0, ex_operation}, 32'h8);
    chk("srl_op2_mask", ex_operand2, 32'h3);
    instr(2'b01, 3'b111, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0);
    step();
    chk("aluop_sub", {28'b0, ex_operation}, 32'h6);
    // Forwarding
    id_rs1 = 5'd5; id_rs2 = 5'd6;
    instr(2'b10, 3'b000, 1'b0, 1'b0, 32'h11, 32'h22, 32'h0);
    step();
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'hBB;
    #1;
    chk("fwd_exmem_wins", ex_operand1, 32'hAA);
    chk("fwd_rs2_none", ex_operand2, 32'h22);
    exmem_reg_write = 1'b0;
    #1;
    chk("fwd_memwb", ex_operand1, 32'hBB);
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1;
    chk("fwd_x0", ex_operand1, 32'h11);
    memwb_rd = 5'd6;
    #1;
    chk("fwd_rs2_op2", ex_operand2, 32'hBB);
    chk("fwd_rs2_store", ex_store_data, 32'hBB);
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0; memwb_rd = 5'd0;
    // Load-use
    id_rd = 5'd7; id_ctrl = 5'b11001; id_rs1 = 5'd0; id_rs2 = 5'd0;
    instr(2'b00, 3'b010, 1'b0, 1'b1, 32'h40, 32'h0, 32'h8);
    step();
    id_rd = 5'd8; id_ctrl = 5'b10000; id_rs1 = 5'd1; id_rs2 = 5'd7;
    instr(2'b10, 3'b000, 1'b0, 1'b0, 32'h1, 32'h2, 32'h0);
    #1;
    chk("lu_stall", {31'b0, load_use_stall}, 32'd1);
    step();
    chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
    chk("lu_bubble_ctrl", {27'b0, ex_ctrl}, 32'd0);
    chk("lu_bubble_rd", {27'b0, ex_rd}, 32'd0);
    chk("lu_bubble_op", {28'b0, ex_operation}, 32'd0);
    chk("lu_release", {31'b0, load_use_stall}, 32'd0);
    step();
    chk("lu_after_valid", {31'b0, ex_valid}, 32'd1);
    chk("lu_after_rd", {27'b0, ex_rd}, 32'd8);
    id_rd = 5'd0; id_ctrl = 5'b11001;
    step();
    id_rs2 = 5'd0; id_rs1 = 5'd0; id_ctrl = 5'b10000;
    #1;
    chk("lu_rd0", {31'b0, load_use_stall}, 32'd0);
    // Stall then flush
    id_pc = 32'h200; id_rd = 5'd9; id_ctrl = 5'b10000;
    instr(2'b10, 3'b110, 1'b0, 1'b0, 32'h3, 32'h4, 32'h0);
    step();
    stall = 1'b1; id_pc = 32'h300; id_rd = 5'd10;
    instr(2'b10, 3'b100, 1'b0, 1'b0, 32'h5, 32'h6, 32'h0);
    step(); step(); step();
    chk("stall_pc", ex_pc, 32'h200);
    chk("stall_rd", {27'b0, ex_rd}, 32'd9);
    chk("stall_op", {28'b0, ex_operation}, 32'h1);
    chk("stall_op1", ex_operand1, 32'h3);
    flush = 1'b1;
    step();
    chk("flush_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_ctrl", {27'b0, ex_ctrl}, 32'd0);
    chk("flush_rd", {27'b0, ex_rd}, 32'd0);
    chk("flush_op", {28'b0, ex_operation}, 32'd0);
    stall = 1'b0; flush = 1'b0;
    // Async reset mid-run
    step();
    chk("pre_rst_valid", {31'b0, ex_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, ex_valid}, 32'd0);
    chk("arst_ctrl", {27'b0, ex_ctrl}, 32'd0);
    chk("arst_op", {28'b0, ex_operation}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
